// File: rtl/gardner_pkg.sv
// Shared types and helpers for the Gardner pre-processor shift AGC.
package gardner_pkg;

  typedef enum logic [2:0] {StIdle, StMeasure, StDecide, StApply, StHold} agc_state_e;

  typedef enum logic [1:0] {DirNone, DirUp, DirDown} agc_dir_e;

  function automatic int unsigned sw_width(input int unsigned max_shift);
    return (max_shift < 1) ? 1 : unsigned'($clog2(max_shift + 1));
  endfunction

  // Most negative w-bit value saturates to the most positive one.
  function automatic logic [63:0] sat_abs(input logic signed [63:0] x, input int unsigned w);
    logic signed [63:0] most_neg;
    most_neg = -(64'sd1 <<< (w - 1));
    if (x == most_neg) return (64'd1 << (w - 1)) - 64'd1;
    else if (x < 0)    return -x;
    else               return x;
  endfunction

endpackage

// File: rtl/gardner_agc_msb_enc.sv
// Priority encoder: index of the highest set bit, -1 when the input is zero.
module gardner_agc_msb_enc #(
  parameter int unsigned W    = 15,
  parameter int unsigned IdxW = $clog2(W) + 1
) (
  input  logic [W-1:0]           value_i,
  output logic signed [IdxW-1:0] idx_o
);

  always_comb begin
    idx_o = '1;
    for (int i = 0; i < W; i++) begin
      if (value_i[i]) idx_o = IdxW'(i);
    end
  end

endmodule

// File: rtl/gardner_shift_agc.sv
// Windowed peak-magnitude AGC that steps the I/Q pre-processor right-shift by one per window.
module gardner_shift_agc
  import gardner_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned WIN_LOG2   = 10,
  parameter int unsigned MAX_SHIFT  = 7,
  parameter int unsigned INIT_SHIFT = 2,
  parameter int          TARGET_MSB = 13
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  input  logic                               freeze,
  input  logic signed [WIDTH-1:0]            I_in_tdata,
  input  logic                               I_in_tvalid,
  input  logic signed [WIDTH-1:0]            Q_in_tdata,
  input  logic                               Q_in_tvalid,
  output logic [sw_width(MAX_SHIFT)-1:0]     shift_out,
  output logic                               shift_upd,
  output logic [WIDTH-2:0]                   peak_out,
  output logic                               win_done
);

  localparam int unsigned SW   = sw_width(MAX_SHIFT);
  localparam int unsigned MagW = WIDTH - 1;
  localparam int unsigned IdxW = $clog2(MagW) + 1;

  agc_state_e          state_q, state_d;
  agc_dir_e            dir_q, dir_d, dir_calc;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [MagW-1:0]     peak_q, peak_d, peak_out_q, peak_out_d;
  logic [SW-1:0]       shift_q, shift_d;
  logic                upd_q, upd_d, win_done_q, win_done_d;

  logic [MagW-1:0]        abs_i, abs_q, mag, peak_next;
  logic signed [IdxW-1:0] msb_idx;
  int                     desired;

  assign abs_i     = MagW'(sat_abs(64'(I_in_tdata), WIDTH));
  assign abs_q     = MagW'(sat_abs(64'(Q_in_tdata), WIDTH));
  assign mag       = (abs_i > abs_q) ? abs_i : abs_q;
  assign peak_next = (mag > peak_q) ? mag : peak_q;

  gardner_agc_msb_enc #(
    .W    (MagW),
    .IdxW (IdxW)
  ) u_msb_enc (
    .value_i (peak_out_q),
    .idx_o   (msb_idx)
  );

  always_comb begin
    desired = int'(msb_idx) - TARGET_MSB;
    if (desired < 0) desired = 0;
    if (desired > int'(MAX_SHIFT)) desired = int'(MAX_SHIFT);
    if (desired > int'(shift_q))      dir_calc = DirUp;
    else if (desired < int'(shift_q)) dir_calc = DirDown;
    else                              dir_calc = DirNone;
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    peak_d     = peak_q;
    peak_out_d = peak_out_q;
    shift_d    = shift_q;
    upd_d      = 1'b0;
    win_done_d = 1'b0;
    // enable=0 outranks freeze, which outranks window completion.
    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
      peak_d  = '0;
    end else if (freeze && (state_q != StIdle)) begin
      state_d = StHold;
      cnt_d   = '0;
      peak_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: if (!freeze) state_d = StMeasure;
        StMeasure: begin
          if (I_in_tvalid && Q_in_tvalid) begin
            cnt_d  = cnt_q + WIN_LOG2'(1);
            peak_d = peak_next;
            if (&cnt_q) begin
              peak_out_d = peak_next;
              win_done_d = 1'b1;
              state_d    = StDecide;
            end
          end
        end
        StDecide: begin
          dir_d   = dir_calc;
          state_d = StApply;
        end
        StApply: begin
          if (dir_q == DirUp) begin
            shift_d = shift_q + SW'(1);
            upd_d   = 1'b1;
          end else if (dir_q == DirDown) begin
            shift_d = shift_q - SW'(1);
            upd_d   = 1'b1;
          end
          cnt_d   = '0;
          peak_d  = '0;
          state_d = StMeasure;
        end
        StHold:  state_d = StMeasure;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dir_q      <= DirNone;
      cnt_q      <= '0;
      peak_q     <= '0;
      peak_out_q <= '0;
      shift_q    <= SW'(INIT_SHIFT);
      upd_q      <= 1'b0;
      win_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      peak_q     <= peak_d;
      peak_out_q <= peak_out_d;
      shift_q    <= shift_d;
      upd_q      <= upd_d;
      win_done_q <= win_done_d;
    end
  end

  assign shift_out = shift_q;
  assign shift_upd = upd_q;
  assign peak_out  = peak_out_q;
  assign win_done  = win_done_q;

endmodule
